load_aligner: RTL

Load-side counterpart to the store alignment path in the RV32I datapath. It accepts a load request from the MEM stage, issues a word-aligned read to the data memory port, waits for the memory response, and extracts the addressed byte, halfword or word. The result is sign- or zero-extended per funct3 and returned to writeback with a one-cycle done pulse. Misaligned and unsupported loads are rejected without touching memory.

---
 rtl/load_aligner.sv | 111 +++++++++++
 1 files changed

// File: rtl/load_aligner.sv
// RV32I load alignment: issues a word-aligned read, extracts and extends the addressed
// byte/halfword/word, and flags misaligned or unsupported loads without touching memory.
module load_aligner #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_req,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_address,
    output logic             o_busy,
    output logic             o_mem_read,
    output logic [WIDTH-1:0] o_mem_address,
    input  logic [31:0]      i_mem_rdata,
    input  logic             i_mem_resp,
    output logic [31:0]      o_rd_data,
    output logic             o_load_done,
    output logic             o_load_err
);

    // state  | meaning
    // S_IDLE | waiting for i_load_req
    // S_WAIT | read strobe high, waiting for i_mem_resp
    // S_DONE | one-cycle completion pulse, error flag valid
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t           r_state;
    logic [2:0]       r_funct3;
    logic [1:0]       r_offset;
    logic [WIDTH-1:0] r_mem_address;
    logic [31:0]      r_rd_data;
    logic             r_err;

    logic             w_req_err;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;

    always_comb begin
        w_req_err = 1'b0;
        case (i_funct3)
            F3_LB, F3_LBU: w_req_err = 1'b0;
            F3_LH, F3_LHU: w_req_err = i_address[0];
            F3_LW:         w_req_err = (i_address[1:0] != 2'b00);
            default:       w_req_err = 1'b1;
        endcase
    end

    // Lane select uses the offset latched at request, not the live address input.
    always_comb begin
        w_byte      = i_mem_rdata[8*r_offset +: 8];
        w_half      = r_offset[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        w_load_data = i_mem_rdata;
        case (r_funct3)
            F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  w_load_data = {24'd0, w_byte};
            F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_funct3      <= 3'd0;
            r_offset      <= 2'd0;
            r_mem_address <= '0;
            r_rd_data     <= 32'd0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_req) begin
                        r_funct3      <= i_funct3;
                        r_offset      <= i_address[1:0];
                        r_mem_address <= {i_address[WIDTH-1:2], 2'b00};
                        r_err         <= w_req_err;
                        r_state       <= w_req_err ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mem_resp) begin
                        r_rd_data <= w_load_data;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_mem_read    = (r_state == S_WAIT);
    assign o_load_done   = (r_state == S_DONE);
    assign o_load_err    = (r_state == S_DONE) && r_err;
    assign o_mem_address = r_mem_address;
    assign o_rd_data     = r_rd_data;

endmodule
